topk_component_sweep: RTL and testbench
=======================================

TOPK_COMPONENT_SWEEP -- requirements
Module: topk_component_sweep

Interface
REQ-001 SHALL have parameter MAX_NODE_COUNT, default 1000, meaning the largest union-find node count that can be swept.
REQ-002 SHALL have localparam INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT), meaning the node index width.
REQ-003 SHALL have parameter SIZE_BIT_WIDTH, default $clog2(MAX_NODE_COUNT+1), meaning the component size width; it is independent of the index width.
REQ-004 SHALL have parameter TOP_N, default 3, range 1..8, meaning the number of ranked slots.
REQ-005 SHALL have localparam PRODUCT_BIT_WIDTH = SIZE_BIT_WIDTH*TOP_N, meaning the product width.
REQ-006 SHALL have parameter READ_LATENCY, default 1, meaning the fixed union-find response delay in cycles.
REQ-007 Ports SHALL be, in this order:
- clk  in  1  the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request.
- start_ready  out  1  high only in IDLE.
- node_count  in  INDEX_BIT_WIDTH+1  number of nodes to sweep, sampled when start is accepted.
- rd_valid  out  1  union-find read strobe.
- rd_index  out  INDEX_BIT_WIDTH  node index being read.
- rsp_valid  in  1  response strobe, arrives READ_LATENCY cycles after rd_valid, in order.
- rsp_is_root  in  1  responding node is a root.
- rsp_size  in  SIZE_BIT_WIDTH  component size of the responding node.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- top_sizes  out  [TOP_N] x SIZE_BIT_WIDTH  ranked component sizes, largest first.
- top_roots  out  [TOP_N] x INDEX_BIT_WIDTH  root index of each ranked slot.
- top_slot_valid  out  TOP_N  occupied-slot mask.
- top_product  out  PRODUCT_BIT_WIDTH  product of the occupied slot sizes.
- component_count  out  INDEX_BIT_WIDTH+1  number of roots seen in the sweep.

Function
REQ-008 FSM states SHALL be IDLE, SWEEP, DRAIN, PRODUCT, DONE.
REQ-009 start SHALL be accepted only when start && start_ready; start in any other state SHALL be ignored.
REQ-010 On acceptance the block SHALL load node_count clamped to MAX_NODE_COUNT, clear all slots, the product and the count, then enter SWEEP.
REQ-011 In SWEEP, rd_valid SHALL be high for exactly N consecutive cycles with rd_index = 0..N-1 in order; after the last read the block SHALL enter DRAIN.
REQ-012 When N = 0, the block SHALL skip SWEEP and DRAIN, enter PRODUCT directly, and set out_valid with all slots invalid and top_product = 0.
REQ-013 The block SHALL count responses; DRAIN SHALL exit to PRODUCT in the cycle after the Nth rsp_valid.
REQ-014 Each rsp_valid with rsp_is_root SHALL increment component_count.
REQ-015 Each root response SHALL be inserted at the first slot d whose size is strictly less than rsp_size, or which is invalid; lower slots SHALL shift down by one and the last slot SHALL drop.
REQ-016 A root whose size equals an existing slot size SHALL rank below it (earlier index wins ties).
REQ-017 A root with rsp_size = 0 SHALL still be inserted into an invalid slot.
REQ-018 Non-root responses SHALL leave the slots unchanged.
REQ-019 PRODUCT SHALL take exactly TOP_N cycles with one multiply per cycle: acc starts at 1, and acc *= size for valid slots only.
REQ-020 top_product SHALL be 0 if no slot is valid.
REQ-021 No intermediate result SHALL truncate within PRODUCT_BIT_WIDTH.
REQ-022 out_valid SHALL rise TOP_N cycles after the Nth response and hold, with all outputs stable, until out_ready; the block SHALL then return to IDLE.
REQ-023 top_* and component_count SHALL retain their values after handshake until the next start is accepted.
REQ-024 rsp_valid outside SWEEP/DRAIN SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE.
REQ-026 Reset SHALL clear all outputs to 0, except start_ready, which SHALL be 1 after reset.
REQ-027 Reset mid-sweep SHALL abandon the sweep; responses still in flight after deassertion SHALL be ignored.

Configuration
REQ-028 With TOPK_COMPONENT_COUNT_EN defined, component_count SHALL be maintained per REQ-014.
REQ-029 With TOPK_COMPONENT_COUNT_EN undefined, the counter logic SHALL be absent and component_count SHALL be tied to 0; all other behaviour is unchanged.

Structure
REQ-030 day08_pkg SHALL hold the FSM state enum and the slot struct {size, root, valid}.
REQ-031 Insertion/shift logic SHALL live in sub-module topk_slot_array (parameters TOP_N, SIZE_BIT_WIDTH, INDEX_BIT_WIDTH; registered slots, clear and insert inputs).

Verification
REQ-032 N=10, roots {0:5, 3:4, 7:1}, READ_LATENCY=1 -> sizes {5,4,1}, roots {0,3,7}, product 20, count 3.
REQ-033 N=6, roots {1:2, 2:2, 4:2} -> roots {1,2,4} in index order (tie rule), product 8.
REQ-034 N=4, single root 0 of size 4, TOP_N=3 -> valid mask 001, product 4, count 1.
REQ-035 N=0 -> out_valid exactly TOP_N+1 cycles after start, product 0, mask 0.
REQ-036 rst_n pulsed at read 5 of 10, then a new sweep -> clean result with no stale slots; out_ready held low for 20 cycles -> outputs stable and start_ready low throughout.
REQ-037 node_count = MAX_NODE_COUNT+1 -> exactly MAX_NODE_COUNT reads; READ_LATENCY=3 -> same results as latency 1.

Source files
------------

// File: rtl/day08_pkg.sv
// Shared types for the top-k component sweep: FSM state encoding and ranked-slot record.
// The slot_t field widths track the default sweep sizing (MAX_NODE_COUNT = 1000).
package day08_pkg;

  localparam int SLOT_SIZE_W = 10;
  localparam int SLOT_ROOT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRODUCT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [SLOT_SIZE_W-1:0] size;
    logic [SLOT_ROOT_W-1:0] root;
    logic                   valid;
  } slot_t;

endpackage

// File: rtl/topk_slot_array.sv
// Registered ranked slots, largest size first; a new root lands above the first smaller
// or empty slot and everything below moves down one place, so equal sizes keep arrival order.
module topk_slot_array
  import day08_pkg::*;
#(
  parameter int TOP_N           = 3,
  parameter int SIZE_BIT_WIDTH  = SLOT_SIZE_W,
  parameter int INDEX_BIT_WIDTH = SLOT_ROOT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       insert,
  input  logic [SIZE_BIT_WIDTH-1:0]  ins_size,
  input  logic [INDEX_BIT_WIDTH-1:0] ins_root,
  output slot_t [TOP_N-1:0]          slots
);

  slot_t [TOP_N-1:0] slots_q, slots_d;
  slot_t             new_slot;
  logic [TOP_N-1:0]  hit;
  logic              above;

  always_comb begin
    new_slot.size  = SLOT_SIZE_W'(ins_size);
    new_slot.root  = SLOT_ROOT_W'(ins_root);
    new_slot.valid = 1'b1;
    for (int i = 0; i < TOP_N; i++) begin
      hit[i] = !slots_q[i].valid || (slots_q[i].size < new_slot.size);
    end
    above   = 1'b0;
    slots_d = slots_q;
    if (clear) begin
      slots_d = '0;
    end else if (insert) begin
      if (hit[0]) slots_d[0] = new_slot;
      above = hit[0];
      for (int i = 1; i < TOP_N; i++) begin
        if (above) begin
          slots_d[i] = slots_q[i-1];
        end else if (hit[i]) begin
          slots_d[i] = new_slot;
        end
        above = above | hit[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slots_q <= '0;
    else        slots_q <= slots_d;
  end

  assign slots = slots_q;

endmodule

// File: rtl/topk_component_sweep.sv
// Sweeps union-find nodes 0..N-1, ranks the TOP_N largest root components and multiplies them.
// Optional root counter enabled by defining TOPK_COMPONENT_COUNT_EN; otherwise component_count is 0.
//
// state   | meaning
// IDLE    | waiting for start, results from last sweep held
// SWEEP   | issuing one read per cycle for index 0..N-1
// DRAIN   | reads done, collecting remaining responses
// PRODUCT | one multiply per slot, TOP_N cycles
// DONE    | out_valid high until out_ready
module topk_component_sweep
  import day08_pkg::*;
#(
  parameter  int MAX_NODE_COUNT    = 1000,
  localparam int INDEX_BIT_WIDTH   = $clog2(MAX_NODE_COUNT),
  parameter  int SIZE_BIT_WIDTH    = $clog2(MAX_NODE_COUNT + 1),
  parameter  int TOP_N             = 3,
  localparam int PRODUCT_BIT_WIDTH = SIZE_BIT_WIDTH * TOP_N,
  parameter  int READ_LATENCY      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  output logic                                    start_ready,
  input  logic [INDEX_BIT_WIDTH:0]                node_count,
  output logic                                    rd_valid,
  output logic [INDEX_BIT_WIDTH-1:0]              rd_index,
  input  logic                                    rsp_valid,
  input  logic                                    rsp_is_root,
  input  logic [SIZE_BIT_WIDTH-1:0]               rsp_size,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [TOP_N-1:0][SIZE_BIT_WIDTH-1:0]    top_sizes,
  output logic [TOP_N-1:0][INDEX_BIT_WIDTH-1:0]   top_roots,
  output logic [TOP_N-1:0]                        top_slot_valid,
  output logic [PRODUCT_BIT_WIDTH-1:0]            top_product,
  output logic [INDEX_BIT_WIDTH:0]                component_count
);

  localparam int                   PIDX_W   = (TOP_N > 1) ? $clog2(TOP_N) : 1;
  localparam logic [INDEX_BIT_WIDTH:0] MAX_N    = (INDEX_BIT_WIDTH+1)'(MAX_NODE_COUNT);
  localparam logic [INDEX_BIT_WIDTH:0] CNT_ONE  = (INDEX_BIT_WIDTH+1)'(1);
  localparam bit                   ZERO_LAT = (READ_LATENCY == 0);

  state_e                          state_q, state_d;
  logic [INDEX_BIT_WIDTH:0]        n_q, n_d, rd_cnt_q, rd_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [PIDX_W-1:0]               pidx_q, pidx_d;
  logic [PRODUCT_BIT_WIDTH-1:0]    acc_q, acc_d, product_q, product_d;
  logic [INDEX_BIT_WIDTH:0]        n_clamped;
  logic                            accept, in_sweep, rsp_take, rsp_last, rd_last;
  logic                            slot_insert, sel_valid;
  logic [SLOT_SIZE_W-1:0]          sel_size;
  slot_t [TOP_N-1:0]               slots;

  assign accept      = start && (state_q == ST_IDLE);
  assign n_clamped   = (node_count > MAX_N) ? MAX_N : node_count;
  assign in_sweep    = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign rsp_take    = rsp_valid && in_sweep;
  assign rsp_last    = rsp_take && (rsp_cnt_q == n_q - CNT_ONE);
  assign rd_last     = (state_q == ST_SWEEP) && (rd_cnt_q == n_q - CNT_ONE);
  assign slot_insert = rsp_take && rsp_is_root;

  topk_slot_array #(
    .TOP_N           (TOP_N),
    .SIZE_BIT_WIDTH  (SIZE_BIT_WIDTH),
    .INDEX_BIT_WIDTH (INDEX_BIT_WIDTH)
  ) u_slots (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .insert   (slot_insert),
    .ins_size (rsp_size),
    .ins_root (rd_index_of_rsp()),
    .slots    (slots)
  );

  // Root index of a response is its position in the in-order response stream.
  function automatic logic [INDEX_BIT_WIDTH-1:0] rd_index_of_rsp();
    return rsp_cnt_q[INDEX_BIT_WIDTH-1:0];
  endfunction

  always_comb begin
    sel_size  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < TOP_N; i++) begin
      if (pidx_q == PIDX_W'(i)) begin
        sel_size  = slots[i].size;
        sel_valid = slots[i].valid;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rd_cnt_d  = rd_cnt_q;
    rsp_cnt_d = rsp_take ? rsp_cnt_q + CNT_ONE : rsp_cnt_q;
    pidx_d    = pidx_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          n_d       = n_clamped;
          rd_cnt_d  = '0;
          rsp_cnt_d = '0;
          pidx_d    = '0;
          acc_d     = PRODUCT_BIT_WIDTH'(1);
          product_d = '0;
          state_d   = (n_clamped == '0) ? ST_PRODUCT : ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (rd_last) state_d = (ZERO_LAT && rsp_last) ? ST_PRODUCT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rsp_last) state_d = ST_PRODUCT;
      end
      ST_PRODUCT: begin
        if (sel_valid) acc_d = acc_q * PRODUCT_BIT_WIDTH'(sel_size);
        pidx_d = pidx_q + PIDX_W'(1);
        if (pidx_q == PIDX_W'(TOP_N - 1)) begin
          product_d = slots[0].valid ? acc_d : '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      rd_cnt_q  <= '0;
      rsp_cnt_q <= '0;
      pidx_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      rd_cnt_q  <= rd_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      pidx_q    <= pidx_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

`ifdef TOPK_COMPONENT_COUNT_EN
  logic [INDEX_BIT_WIDTH:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept)           count_d = '0;
    else if (slot_insert) count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign component_count = count_q;
`else
  assign component_count = '0;
`endif

  always_comb begin
    for (int i = 0; i < TOP_N; i++) begin
      top_sizes[i]      = SIZE_BIT_WIDTH'(slots[i].size);
      top_roots[i]      = INDEX_BIT_WIDTH'(slots[i].root);
      top_slot_valid[i] = slots[i].valid;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign rd_valid    = (state_q == ST_SWEEP);
  assign rd_index    = rd_cnt_q[INDEX_BIT_WIDTH-1:0];
  assign top_product = product_q;

endmodule

// File: tb/tb_topk_component_sweep.sv
// Self-checking bench: two sweeps engines (response latency 1 and 3) against a ranking model.
module tb_topk_component_sweep;

  localparam int MAXN = 1000;
  localparam int IW   = 10;
  localparam int SW   = 10;
  localparam int TN   = 3;
  localparam int PW   = SW * TN;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                    start_s       [2];
  logic                    start_ready_s [2];
  logic [IW:0]             node_count_s  [2];
  logic                    rd_valid_s    [2];
  logic [IW-1:0]           rd_index_s    [2];
  logic                    rsp_valid_s   [2];
  logic                    rsp_is_root_s [2];
  logic [SW-1:0]           rsp_size_s    [2];
  logic                    out_valid_s   [2];
  logic                    out_ready_s   [2];
  logic [TN-1:0][SW-1:0]   top_sizes_s   [2];
  logic [TN-1:0][IW-1:0]   top_roots_s   [2];
  logic [TN-1:0]           mask_s        [2];
  logic [PW-1:0]           prod_s        [2];
  logic [IW:0]             cnt_s         [2];

  logic                    stray_v [2];
  logic                    stray_root;
  logic [SW-1:0]           stray_size;

  bit                      root_mem [1024];
  logic [SW-1:0]           size_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic          pv [LAT];
    logic [IW-1:0] pi [LAT];
    int            rd_cnt_m = 0;
    logic          prev_rd  = 1'b0;

    topk_component_sweep #(
      .MAX_NODE_COUNT (MAXN),
      .TOP_N          (TN),
      .READ_LATENCY   (LAT)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start_s[g]),
      .start_ready     (start_ready_s[g]),
      .node_count      (node_count_s[g]),
      .rd_valid        (rd_valid_s[g]),
      .rd_index        (rd_index_s[g]),
      .rsp_valid       (rsp_valid_s[g]),
      .rsp_is_root     (rsp_is_root_s[g]),
      .rsp_size        (rsp_size_s[g]),
      .out_valid       (out_valid_s[g]),
      .out_ready       (out_ready_s[g]),
      .top_sizes       (top_sizes_s[g]),
      .top_roots       (top_roots_s[g]),
      .top_slot_valid  (mask_s[g]),
      .top_product     (prod_s[g]),
      .component_count (cnt_s[g])
    );

    // Union-find memory model: fixed-latency, in-order responses.
    always @(posedge clk) begin
      pv[0] <= rd_valid_s[g];
      pi[0] <= rd_index_s[g];
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pi[k] <= pi[k-1];
      end
    end

    assign rsp_valid_s[g]   = pv[LAT-1] | stray_v[g];
    assign rsp_is_root_s[g] = stray_v[g] ? stray_root : (pv[LAT-1] & root_mem[pi[LAT-1]]);
    assign rsp_size_s[g]    = stray_v[g] ? stray_size : size_mem[pi[LAT-1]];

    always @(negedge clk) begin
      if (rd_valid_s[g]) begin
        if (!prev_rd) rd_cnt_m = 0;
        chk($sformatf("rd_index_dut%0d", g), 64'(rd_index_s[g]), 64'(rd_cnt_m));
        rd_cnt_m++;
      end
      prev_rd = rd_valid_s[g];
    end
  end

  int          exp_size [TN];
  int          exp_root [TN];
  logic [TN-1:0] exp_mask;
  longint      exp_prod;
  int          exp_cnt;

  // Reference: pick the largest remaining root each slot, earliest index on ties.
  task automatic model(input int n);
    bit taken [1024];
    int m, best;
    m = (n > MAXN) ? MAXN : n;
    exp_cnt  = 0;
    exp_mask = '0;
    exp_prod = 1;
    for (int i = 0; i < m; i++) if (root_mem[i]) exp_cnt++;
    for (int s = 0; s < TN; s++) begin
      best = -1;
      for (int i = 0; i < m; i++) begin
        if (root_mem[i] && !taken[i] && (best < 0 || int'(size_mem[i]) > int'(size_mem[best])))
          best = i;
      end
      exp_size[s] = 0;
      exp_root[s] = 0;
      if (best >= 0) begin
        taken[best] = 1'b1;
        exp_mask[s] = 1'b1;
        exp_size[s] = int'(size_mem[best]);
        exp_root[s] = best;
        exp_prod    = exp_prod * longint'(size_mem[best]);
      end
    end
    if (exp_mask == '0) exp_prod = 0;
  endtask

  task automatic check_result(input int w, input int n, input string tag);
    int ec;
    model(n);
`ifdef TOPK_COMPONENT_COUNT_EN
    ec = exp_cnt;
`else
    ec = 0;
`endif
    chk({tag, "_mask"}, 64'(mask_s[w]), 64'(exp_mask));
    for (int s = 0; s < TN; s++) begin
      if (exp_mask[s]) begin
        chk($sformatf("%s_size%0d", tag, s), 64'(top_sizes_s[w][s]), 64'(exp_size[s]));
        chk($sformatf("%s_root%0d", tag, s), 64'(top_roots_s[w][s]), 64'(exp_root[s]));
      end
    end
    chk({tag, "_product"}, 64'(prod_s[w]), 64'(exp_prod));
    chk({tag, "_count"}, 64'(cnt_s[w]), 64'(ec));
  endtask

  task automatic run_sweep(input int w, input int n, output int lat);
    int k;
    @(negedge clk);
    chk("start_ready_pre", 64'(start_ready_s[w]), 64'd1);
    node_count_s[w] = (IW+1)'(n);
    start_s[w]      = 1'b1;
    @(negedge clk);
    start_s[w] = 1'b0;
    k = 1;
    while (!out_valid_s[w] && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_timeout", 64'(out_valid_s[w]), 64'd1);
    lat = k;
  endtask

  task automatic handshake(input int w);
    out_ready_s[w] = 1'b1;
    @(negedge clk);
    out_ready_s[w] = 1'b0;
    chk("idle_after_hs", 64'(start_ready_s[w]), 64'd1);
    chk("out_valid_after_hs", 64'(out_valid_s[w]), 64'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      root_mem[i] = 1'b0;
      size_mem[i] = SW'($urandom_range(0, 1023));
    end
  endtask

  task automatic random_mem(input int n, input int max_size);
    for (int i = 0; i < n; i++) begin
      root_mem[i] = ($urandom_range(0, 2) == 0);
      size_mem[i] = SW'($urandom_range(0, max_size));
    end
  endtask

  initial begin
    int lat, k, n;
    for (int w = 0; w < 2; w++) begin
      start_s[w]      = 1'b0;
      node_count_s[w] = '0;
      out_ready_s[w]  = 1'b0;
      stray_v[w]      = 1'b0;
    end
    stray_root = 1'b0;
    stray_size = '0;
    clear_mem();

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 64'(start_ready_s[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid_s[0]), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_s[0]), 64'd0);
    chk("rst_mask", 64'(mask_s[0]), 64'd0);
    chk("rst_product", 64'(prod_s[0]), 64'd0);
    chk("rst_count", 64'(cnt_s[0]), 64'd0);
    chk("rst_sizes", 64'(top_sizes_s[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray responses while idle must not leak into the next sweep.
    stray_root = 1'b1;
    stray_size = SW'(999);
    stray_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    stray_v[0] = 1'b0;

    clear_mem();
    root_mem[0] = 1'b1; size_mem[0] = SW'(5);
    root_mem[3] = 1'b1; size_mem[3] = SW'(4);
    root_mem[7] = 1'b1; size_mem[7] = SW'(1);
    run_sweep(0, 10, lat);
    check_result(0, 10, "r032");
    chk("r032_product_const", 64'(prod_s[0]), 64'd20);
    handshake(0);
    run_sweep(1, 10, lat);
    check_result(1, 10, "r032_lat3");
    chk("r032_lat3_product_const", 64'(prod_s[1]), 64'd20);
    handshake(1);

    clear_mem();
    root_mem[1] = 1'b1; size_mem[1] = SW'(2);
    root_mem[2] = 1'b1; size_mem[2] = SW'(2);
    root_mem[4] = 1'b1; size_mem[4] = SW'(2);
    run_sweep(0, 6, lat);
    check_result(0, 6, "r033");
    chk("r033_root1_const", 64'(top_roots_s[0][1]), 64'd2);
    handshake(0);

    clear_mem();
    root_mem[0] = 1'b1; size_mem[0] = SW'(4);
    run_sweep(0, 4, lat);
    check_result(0, 4, "r034");
    chk("r034_mask_const", 64'(mask_s[0]), 64'b001);
    handshake(0);

    run_sweep(0, 0, lat);
    chk("r035_latency", 64'(lat), 64'(TN + 1));
    check_result(0, 0, "r035");
    handshake(0);

    // Zero-size root still takes an empty slot.
    clear_mem();
    root_mem[2] = 1'b1; size_mem[2] = SW'(0);
    root_mem[5] = 1'b1; size_mem[5] = SW'(3);
    run_sweep(0, 8, lat);
    check_result(0, 8, "zero_size");
    handshake(0);

    // Reset at read 5, then a clean sweep and a long output hold.
    random_mem(10, 9);
    @(negedge clk);
    node_count_s[0] = (IW+1)'(10);
    start_s[0]      = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    k = 0;
    while (!(rd_valid_s[0] && rd_index_s[0] == IW'(5)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("r036_reached_read5", 64'(rd_valid_s[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("r036_rst_start_ready", 64'(start_ready_s[0]), 64'd1);
    chk("r036_rst_rd_valid", 64'(rd_valid_s[0]), 64'd0);
    chk("r036_rst_mask", 64'(mask_s[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mem();
    root_mem[9] = 1'b1; size_mem[9] = SW'(7);
    root_mem[4] = 1'b1; size_mem[4] = SW'(2);
    run_sweep(0, 10, lat);
    check_result(0, 10, "r036_after_rst");
    for (int c = 0; c < 20; c++) begin
      start_s[0] = (c == 10);
      @(negedge clk);
      chk("r036_hold_out_valid", 64'(out_valid_s[0]), 64'd1);
      chk("r036_hold_start_ready", 64'(start_ready_s[0]), 64'd0);
      chk("r036_hold_product", 64'(prod_s[0]), 64'(exp_prod));
      chk("r036_hold_mask", 64'(mask_s[0]), 64'(exp_mask));
    end
    start_s[0] = 1'b0;
    handshake(0);
    repeat (2) @(negedge clk);
    chk("r036_no_restart", 64'(rd_valid_s[0]), 64'd0);
    check_result(0, 10, "r036_retained");

    // Oversized node_count clamps to MAX_NODE_COUNT reads.
    random_mem(1024, 1023);
    run_sweep(0, MAXN + 1, lat);
    chk("r037_read_count", 64'(g_dut[0].rd_cnt_m), 64'(MAXN));
    check_result(0, MAXN + 1, "r037_clamp");
    handshake(0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      random_mem(n, 6);
      run_sweep(r % 2, n, lat);
      check_result(r % 2, n, $sformatf("rand%0d", r));
      handshake(r % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
